y86_fetch_decode_exec: RTL and testbench

- Front half of the Y86-64 sequential (SEQ) processor: fetch, decode, execute and writeback.
- Fetch: combinational decoding of a 10-byte instruction window supplied for the current PC.
- Decode: reads a 15-entry register file.
- Execute: computes valE/cnd; updates condition codes and the register file on the clock edge.
- Integration: PC sequencing and data memory are external; the memory stage supplies valM back for writeback.

---
 rtl/y86_fetch_decode_exec.sv | 214 +++++++++++++++++++++
 tb/tb_y86_fetch_decode_exec.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch_decode_exec.sv
// y86_fetch_decode_exec
//   Fetch, decode, execute and writeback of a Y86-64 SEQ processor.
//   Fetch, decode and execute are combinational over the supplied 10-byte
//   instruction window. The register file (15 x 64) and condition codes are
//   updated on the rising clock edge. PC sequencing and data memory are
//   external: the memory stage returns valM for writeback.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   pc                  address of the current instruction
//   instruction         bytes pc..pc+9, byte 0 in [79:72]
//   valM                data-memory read value for the current instruction
//   icode, ifun, rA, rB instruction fields (rA/rB = 0xF when absent)
//   valC, valP          constant field, next sequential PC
//   valA, valB          decoded operands
//   valE, cnd           ALU result, condition result
//   cc                  condition codes {ZF,SF,OF}
//   instr_valid         icode in 0..11
//   imem_error          pc outside instruction memory
//   halt                valid halt instruction
module y86_fetch_decode_exec #(
   parameter int unsigned MEM_SIZE = 65536
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [63:0]  pc,
   input  logic [79:0]  instruction,
   input  logic [63:0]  valM,
   output logic [3:0]   icode,
   output logic [3:0]   ifun,
   output logic [3:0]   rA,
   output logic [3:0]   rB,
   output logic [63:0]  valC,
   output logic [63:0]  valP,
   output logic [63:0]  valA,
   output logic [63:0]  valB,
   output logic [63:0]  valE,
   output logic         cnd,
   output logic [2:0]   cc,
   output logic         instr_valid,
   output logic         imem_error,
   output logic         halt
);

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_RRMOV = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [3:0] R_RSP   = 4'h4;
   localparam logic [3:0] R_NONE  = 4'hF;

   logic [63:0] regs_q [15];
   logic [63:0] regs_d [15];
   logic [2:0]  cc_q;
   logic [2:0]  cc_d;

   logic [3:0]  ilen;
   logic [63:0] add_res;
   logic [63:0] sub_res;
   logic        cond;
   logic        ovf;
   logic [2:0]  cc_new;
   logic [3:0]  dst_e;
   logic [3:0]  dst_m;
   logic        wr_en;

   assign cc = cc_q;

   // Fetch
   always_comb begin
      icode       = instruction[79:76];
      ifun        = instruction[75:72];
      instr_valid = (icode <= I_POP);
      imem_error  = (pc >= 64'(MEM_SIZE));
      halt        = instr_valid && (icode == I_HALT);

      rA = R_NONE;
      rB = R_NONE;
      case (icode)
         I_RRMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OPQ, I_PUSH, I_POP: begin
            rA = instruction[71:68];
            rB = instruction[67:64];
         end
         default: ;
      endcase

      valC = 64'd0;
      case (icode)
         I_IRMOV, I_RMMOV, I_MRMOV: valC = instruction[63:0];
         I_JXX, I_CALL:             valC = instruction[71:8];
         default: ;
      endcase

      case (icode)
         I_HALT, I_NOP, I_RET:             ilen = 4'd1;
         I_RRMOV, I_OPQ, I_PUSH, I_POP:    ilen = 4'd2;
         I_JXX, I_CALL:                    ilen = 4'd9;
         I_IRMOV, I_RMMOV, I_MRMOV:        ilen = 4'd10;
         default:                          ilen = 4'd1;
      endcase
      valP = pc + {60'd0, ilen};
   end

   // Decode: register 0xF reads as zero
   always_comb begin
      valA = 64'd0;
      case (icode)
         I_RRMOV, I_RMMOV, I_OPQ, I_PUSH: valA = (rA == R_NONE) ? 64'd0 : regs_q[rA];
         I_RET, I_POP:                    valA = regs_q[R_RSP];
         default: ;
      endcase

      valB = 64'd0;
      case (icode)
         I_RMMOV, I_MRMOV, I_OPQ:         valB = (rB == R_NONE) ? 64'd0 : regs_q[rB];
         I_CALL, I_RET, I_PUSH, I_POP:    valB = regs_q[R_RSP];
         default: ;
      endcase
   end

   // Execute
   always_comb begin
      add_res = valB + valA;
      sub_res = valB - valA;

      case (ifun)
         4'd0:    cond = 1'b1;
         4'd1:    cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
         4'd2:    cond = cc_q[1] ^ cc_q[0];
         4'd3:    cond = cc_q[2];
         4'd4:    cond = ~cc_q[2];
         4'd5:    cond = ~(cc_q[1] ^ cc_q[0]);
         4'd6:    cond = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
         default: cond = 1'b0;
      endcase
      cnd = cond && ((icode == I_RRMOV) || (icode == I_JXX));

      valE = 64'd0;
      ovf  = 1'b0;
      case (icode)
         I_RRMOV:          valE = valA;
         I_IRMOV:          valE = valC;
         I_RMMOV, I_MRMOV: valE = valB + valC;
         I_CALL, I_PUSH:   valE = valB - 64'd8;
         I_RET, I_POP:     valE = valB + 64'd8;
         I_OPQ: begin
            case (ifun)
               4'd0: begin
                  valE = add_res;
                  ovf  = (valA[63] == valB[63]) && (add_res[63] != valA[63]);
               end
               4'd1: begin
                  valE = sub_res;
                  ovf  = (valA[63] != valB[63]) && (sub_res[63] != valB[63]);
               end
               4'd2:    valE = valB & valA;
               4'd3:    valE = valB ^ valA;
               default: valE = 64'd0;
            endcase
         end
         default: ;
      endcase
      cc_new = {(valE == 64'd0), valE[63], ovf};
   end

   // Writeback
   always_comb begin
      wr_en = instr_valid && !imem_error && !halt;

      dst_e = R_NONE;
      case (icode)
         I_RRMOV:                      dst_e = cnd ? rB : R_NONE;
         I_IRMOV, I_OPQ:               dst_e = rB;
         I_CALL, I_RET, I_PUSH, I_POP: dst_e = R_RSP;
         default: ;
      endcase

      dst_m = R_NONE;
      case (icode)
         I_MRMOV, I_POP: dst_m = rA;
         default: ;
      endcase

      cc_d = cc_q;
      if (wr_en && (icode == I_OPQ)) cc_d = cc_new;

      // The M port is applied last so it wins when both target one register
      for (int i = 0; i < 15; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_en && (dst_e == 4'(i))) regs_d[i] = valE;
         if (wr_en && (dst_m == 4'(i))) regs_d[i] = valM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_q <= 3'b000;
         for (int i = 0; i < 15; i++) regs_q[i] <= 64'd0;
      end else begin
         cc_q <= cc_d;
         for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
      end
   end

endmodule

// File: tb/tb_y86_fetch_decode_exec.sv
module tb_y86_fetch_decode_exec;

   localparam int unsigned MEM_SIZE = 65536;

   logic         clk;
   logic         rst_n;
   logic [63:0]  pc;
   logic [79:0]  instruction;
   logic [63:0]  valM;
   logic [3:0]   icode, ifun, rA, rB;
   logic [63:0]  valC, valP, valA, valB, valE;
   logic         cnd;
   logic [2:0]   cc;
   logic         instr_valid, imem_error, halt;

   int n_cmp  = 0;
   int n_fail = 0;

   y86_fetch_decode_exec #(.MEM_SIZE(MEM_SIZE)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction), .valM(valM),
      .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
      .valA(valA), .valB(valB), .valE(valE), .cnd(cnd), .cc(cc),
      .instr_valid(instr_valid), .imem_error(imem_error), .halt(halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Reference architectural state
   logic [63:0] m_regs [15];
   logic [2:0]  m_cc;

   // Expected values of the current instruction
   logic [3:0]  e_icode, e_ifun, e_rA, e_rB, e_dstE, e_dstM;
   logic [63:0] e_valC, e_valP, e_valA, e_valB, e_valE, e_valM;
   logic        e_cnd, e_valid, e_imem, e_halt;
   logic [2:0]  e_ccnew;

   function automatic logic [63:0] rdreg(input logic [3:0] r);
      return (r == 4'hF) ? 64'd0 : m_regs[r];
   endfunction

   task automatic ref_eval(input logic [63:0] p, input logic [79:0] ins, input logic [63:0] vm);
      logic [7:0] bb [10];
      logic zf, sf, of_, c;
      int len;
      for (int i = 0; i < 10; i++) bb[i] = ins[79-8*i -: 8];
      e_valM  = vm;
      e_icode = bb[0][7:4];
      e_ifun  = bb[0][3:0];
      e_valid = (e_icode <= 4'd11);
      e_imem  = (p >= 64'(MEM_SIZE));
      e_halt  = e_valid && (e_icode == 4'd0);
      if (e_icode inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11}) begin
         e_rA = bb[1][7:4];
         e_rB = bb[1][3:0];
      end else begin
         e_rA = 4'hF;
         e_rB = 4'hF;
      end
      e_valC = 64'd0;
      if (e_icode inside {4'd3, 4'd4, 4'd5})
         for (int i = 2; i <= 9; i++) e_valC = (e_valC << 8) | 64'(bb[i]);
      else if (e_icode inside {4'd7, 4'd8})
         for (int i = 1; i <= 8; i++) e_valC = (e_valC << 8) | 64'(bb[i]);
      if (e_icode inside {4'd2, 4'd6, 4'd10, 4'd11}) len = 2;
      else if (e_icode inside {4'd7, 4'd8}) len = 9;
      else if (e_icode inside {4'd3, 4'd4, 4'd5}) len = 10;
      else len = 1;
      e_valP = p + 64'(len);

      e_valA = 64'd0;
      if (e_icode inside {4'd2, 4'd4, 4'd6, 4'd10}) e_valA = rdreg(e_rA);
      else if (e_icode inside {4'd9, 4'd11}) e_valA = m_regs[4];
      e_valB = 64'd0;
      if (e_icode inside {4'd4, 4'd5, 4'd6}) e_valB = rdreg(e_rB);
      else if (e_icode inside {4'd8, 4'd9, 4'd10, 4'd11}) e_valB = m_regs[4];

      zf = m_cc[2]; sf = m_cc[1]; of_ = m_cc[0];
      case (e_ifun)
         4'd0: c = 1'b1;
         4'd1: c = (sf != of_) || zf;
         4'd2: c = (sf != of_);
         4'd3: c = zf;
         4'd4: c = !zf;
         4'd5: c = (sf == of_);
         4'd6: c = (sf == of_) && !zf;
         default: c = 1'b0;
      endcase
      e_cnd = (e_icode == 4'd2 || e_icode == 4'd7) ? c : 1'b0;

      of_ = 1'b0;
      case (e_icode)
         4'd2:        e_valE = e_valA;
         4'd3:        e_valE = e_valC;
         4'd4, 4'd5:  e_valE = e_valB + e_valC;
         4'd8, 4'd10: e_valE = e_valB - 64'd8;
         4'd9, 4'd11: e_valE = e_valB + 64'd8;
         4'd6: begin
            case (e_ifun)
               4'd0: begin
                  e_valE = e_valB + e_valA;
                  of_ = (e_valA[63] == e_valB[63]) && (e_valE[63] != e_valA[63]);
               end
               4'd1: begin
                  e_valE = e_valB - e_valA;
                  of_ = (e_valB[63] != e_valA[63]) && (e_valE[63] != e_valB[63]);
               end
               4'd2: e_valE = e_valB & e_valA;
               4'd3: e_valE = e_valB ^ e_valA;
               default: e_valE = 64'd0;
            endcase
         end
         default: e_valE = 64'd0;
      endcase
      e_ccnew = {(e_valE == 64'd0), e_valE[63], of_};

      if (e_icode == 4'd2) e_dstE = e_cnd ? e_rB : 4'hF;
      else if (e_icode inside {4'd3, 4'd6}) e_dstE = e_rB;
      else if (e_icode inside {4'd8, 4'd9, 4'd10, 4'd11}) e_dstE = 4'd4;
      else e_dstE = 4'hF;
      e_dstM = (e_icode inside {4'd5, 4'd11}) ? e_rA : 4'hF;
   endtask

   // Present an instruction and evaluate the reference model for it
   task automatic apply(input logic [63:0] p, input logic [79:0] ins, input logic [63:0] vm);
      pc = p; instruction = ins; valM = vm;
      ref_eval(p, ins, vm);
      #1;
   endtask

   // Clock the instruction in, updating the reference state alongside
   task automatic commit();
      if (rst_n && e_valid && !e_imem && !e_halt) begin
         if (e_dstE != 4'hF) m_regs[e_dstE] = e_valE;
         if (e_dstM != 4'hF) m_regs[e_dstM] = e_valM;
         if (e_icode == 4'd6) m_cc = e_ccnew;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pc = 64'd0; instruction = 80'd0; valM = 64'd0;
      for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
      m_cc = 3'b000;
      #3;
      n_cmp++;
      if (cc !== 3'b000) begin
         n_fail++; $display("FAIL reset_cc: got %b required 000", cc);
      end
      for (int i = 0; i < 15; i++) begin
         n_cmp++;
         if (dut.regs_q[i] !== 64'd0) begin
            n_fail++; $display("FAIL reset_reg%0d: got %h required 0", i, dut.regs_q[i]);
         end
      end
      n_cmp++;
      if (halt !== 1'b1) begin
         n_fail++; $display("FAIL reset_halt_out: got %b required 1", halt);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [63:0] pv;
      // irmovq $31,%rbx at pc 66
      apply(64'd66, {8'h30, 8'hF3, 64'd31}, 64'd0);
      n_cmp++;
      if (rB !== 4'd3 || valC !== 64'd31 || valP !== 64'd76 || valE !== 64'd31) begin
         n_fail++; $display("FAIL irmov_fields: got rB=%0d valC=%0d valP=%0d valE=%0d required 3 31 76 31", rB, valC, valP, valE);
      end
      commit();
      n_cmp++;
      if (dut.regs_q[3] !== 64'd31) begin
         n_fail++; $display("FAIL irmov_wb: got %h required 1f", dut.regs_q[3]);
      end
      // rmmovq %rdx,5(%rsp) at pc 76
      apply(64'd76, {8'h40, 8'h24, 64'd5}, 64'hDEAD);
      n_cmp++;
      if (valE !== 64'd5 || valP !== 64'd86 || valA !== 64'd0) begin
         n_fail++; $display("FAIL rmmov: got valE=%0d valP=%0d valA=%0d required 5 86 0", valE, valP, valA);
      end
      commit();
      // mrmovq 4(%rsp),%rdx
      apply(64'd86, {8'h50, 8'h24, 64'd4}, 64'h1234);
      n_cmp++;
      if (valE !== 64'd4) begin
         n_fail++; $display("FAIL mrmov_valE: got %h required 4", valE);
      end
      commit();
      n_cmp++;
      if (dut.regs_q[2] !== 64'h1234) begin
         n_fail++; $display("FAIL mrmov_wb: got %h required 1234", dut.regs_q[2]);
      end
      // xorq %rdx,%rsp with rdx=0x1234, rsp=0
      apply(64'd96, {8'h63, 8'h24, 64'd0}, 64'd0);
      n_cmp++;
      if (valE !== 64'h1234) begin
         n_fail++; $display("FAIL xor_nz_valE: got %h required 1234", valE);
      end
      commit();
      n_cmp++;
      if (cc !== 3'b000) begin
         n_fail++; $display("FAIL xor_nz_cc: got %b required 000", cc);
      end
      // clear rdx and rsp, then xor again
      apply(64'd98, {8'h30, 8'hF2, 64'd0}, 64'd0); commit();
      apply(64'd108, {8'h30, 8'hF4, 64'd0}, 64'd0); commit();
      apply(64'd118, {8'h63, 8'h24, 64'd0}, 64'd0);
      n_cmp++;
      if (valE !== 64'd0) begin
         n_fail++; $display("FAIL xor_z_valE: got %h required 0", valE);
      end
      commit();
      n_cmp++;
      if (cc !== 3'b100) begin
         n_fail++; $display("FAIL xor_z_cc: got %b required 100", cc);
      end
      // subq %rcx,%rbx with rbx=0x8000..., rcx=1
      apply(64'd120, {8'h30, 8'hF3, 64'h8000_0000_0000_0000}, 64'd0); commit();
      apply(64'd130, {8'h30, 8'hF1, 64'd1}, 64'd0); commit();
      apply(64'd140, {8'h61, 8'h13, 64'd0}, 64'd0); commit();
      n_cmp++;
      if (cc !== 3'b001 || dut.regs_q[3] !== 64'h7FFF_FFFF_FFFF_FFFF) begin
         n_fail++; $display("FAIL sub_overflow: got cc=%b rbx=%h required 001 7fffffffffffffff", cc, dut.regs_q[3]);
      end
      // cmovle %rdx,%rbx with cc=100
      apply(64'd142, {8'h30, 8'hF2, 64'h55}, 64'd0); commit();
      apply(64'd152, {8'h63, 8'h11, 64'd0}, 64'd0); commit();
      apply(64'd154, {8'h21, 8'h23, 64'd0}, 64'd0);
      n_cmp++;
      if (cnd !== 1'b1) begin
         n_fail++; $display("FAIL cmovle_taken_cnd: got %b required 1", cnd);
      end
      commit();
      n_cmp++;
      if (dut.regs_q[3] !== 64'h55) begin
         n_fail++; $display("FAIL cmovle_taken_wb: got %h required 55", dut.regs_q[3]);
      end
      // addq %rdx,%rdx -> cc=000, then cmovle %rdx,%rbx not taken
      apply(64'd156, {8'h60, 8'h22, 64'd0}, 64'd0); commit();
      apply(64'd158, {8'h21, 8'h23, 64'd0}, 64'd0);
      n_cmp++;
      if (cnd !== 1'b0 || cc !== 3'b000) begin
         n_fail++; $display("FAIL cmovle_nt_cnd: got cnd=%b cc=%b required 0 000", cnd, cc);
      end
      commit();
      n_cmp++;
      if (dut.regs_q[3] !== 64'h55) begin
         n_fail++; $display("FAIL cmovle_nt_wb: got %h required 55", dut.regs_q[3]);
      end
      // popq %rdx with rsp=0, valM=7
      apply(64'd160, {8'h30, 8'hF4, 64'd0}, 64'd0); commit();
      apply(64'd170, {8'hB0, 8'h2F, 64'd0}, 64'd7);
      n_cmp++;
      if (valA !== 64'd0 || valB !== 64'd0 || valE !== 64'd8 || valP !== 64'd172) begin
         n_fail++; $display("FAIL pop_fields: got %h %h %h %h required 0 0 8 ac", valA, valB, valE, valP);
      end
      commit();
      n_cmp++;
      if (dut.regs_q[4] !== 64'd8 || dut.regs_q[2] !== 64'd7) begin
         n_fail++; $display("FAIL pop_wb: got rsp=%h rdx=%h required 8 7", dut.regs_q[4], dut.regs_q[2]);
      end
      // popq %rsp -> valM wins
      apply(64'd172, {8'hB0, 8'h4F, 64'd0}, 64'h99); commit();
      n_cmp++;
      if (dut.regs_q[4] !== 64'h99) begin
         n_fail++; $display("FAIL pop_rsp: got %h required 99", dut.regs_q[4]);
      end
      // nop, halt, invalid icode, pc boundary
      apply(64'd200, {8'h10, 72'h3F_0000_0000_0000_0001}, 64'd1);
      n_cmp++;
      if (valP !== 64'd201) begin
         n_fail++; $display("FAIL nop_valP: got %0d required 201", valP);
      end
      commit();
      apply(64'd201, {8'h00, 8'h3F, 64'd5}, 64'd1);
      n_cmp++;
      if (halt !== 1'b1) begin
         n_fail++; $display("FAIL halt_flag: got %b required 1", halt);
      end
      commit();
      apply(64'd202, {8'hC0, 8'h3F, 64'd5}, 64'd1);
      n_cmp++;
      if (instr_valid !== 1'b0 || valE !== 64'd0) begin
         n_fail++; $display("FAIL invalid_icode: got valid=%b valE=%h required 0 0", instr_valid, valE);
      end
      commit();
      pv = 64'(MEM_SIZE);
      apply(pv, {8'h30, 8'hF3, 64'd77}, 64'd0);
      n_cmp++;
      if (imem_error !== 1'b1) begin
         n_fail++; $display("FAIL imem_at_limit: got %b required 1", imem_error);
      end
      commit();
      apply(pv - 64'd1, {8'h30, 8'hF6, 64'd77}, 64'd0);
      n_cmp++;
      if (imem_error !== 1'b0) begin
         n_fail++; $display("FAIL imem_below_limit: got %b required 0", imem_error);
      end
      commit();
      n_cmp++;
      if (dut.regs_q[3] !== 64'h55 || dut.regs_q[6] !== 64'd77) begin
         n_fail++; $display("FAIL boundary_wb: got rbx=%h rsi=%h required 55 4d", dut.regs_q[3], dut.regs_q[6]);
      end
   endtask

   task automatic test_random();
      logic [95:0] r96;
      logic [79:0] ins;
      logic [63:0] p, vm;
      logic [3:0]  ic, fn;
      int sel;
      // seed every register with a random value
      for (int i = 0; i < 15; i++) begin
         apply(64'd0, {8'h30, 4'hF, 4'(i), {$urandom, $urandom}}, 64'd0);
         commit();
      end
      for (int n = 0; n < 400; n++) begin
         r96 = {$urandom, $urandom, $urandom};
         ins = r96[79:0];
         ic = 4'($urandom_range(0, 13));
         if (ic == 4'd6) fn = 4'($urandom_range(0, 4));
         else if (ic == 4'd2 || ic == 4'd7) fn = 4'($urandom_range(0, 7));
         else fn = 4'($urandom_range(0, 1));
         ins[79:72] = {ic, fn};
         sel = int'($urandom_range(0, 15));
         if (sel == 0) p = 64'(MEM_SIZE) + 64'($urandom_range(0, 3));
         else if (sel == 1) p = 64'(MEM_SIZE) - 64'd1;
         else p = 64'($urandom_range(0, MEM_SIZE - 1));
         vm = {$urandom, $urandom};
         apply(p, ins, vm);
         n_cmp++;
         if (icode !== e_icode || ifun !== e_ifun || rA !== e_rA || rB !== e_rB) begin
            n_fail++; $display("FAIL rnd_fields[%0d]: got %h %h %h %h required %h %h %h %h", n, icode, ifun, rA, rB, e_icode, e_ifun, e_rA, e_rB);
         end
         n_cmp++;
         if (valC !== e_valC || valP !== e_valP) begin
            n_fail++; $display("FAIL rnd_valC_valP[%0d]: got %h %h required %h %h", n, valC, valP, e_valC, e_valP);
         end
         n_cmp++;
         if (valA !== e_valA || valB !== e_valB) begin
            n_fail++; $display("FAIL rnd_valA_valB[%0d]: got %h %h required %h %h", n, valA, valB, e_valA, e_valB);
         end
         n_cmp++;
         if (valE !== e_valE) begin
            n_fail++; $display("FAIL rnd_valE[%0d]: icode %h got %h required %h", n, e_icode, valE, e_valE);
         end
         n_cmp++;
         if (cnd !== e_cnd) begin
            n_fail++; $display("FAIL rnd_cnd[%0d]: got %b required %b", n, cnd, e_cnd);
         end
         n_cmp++;
         if (instr_valid !== e_valid || imem_error !== e_imem || halt !== e_halt) begin
            n_fail++; $display("FAIL rnd_status[%0d]: got %b%b%b required %b%b%b", n, instr_valid, imem_error, halt, e_valid, e_imem, e_halt);
         end
         commit();
         n_cmp++;
         if (cc !== m_cc) begin
            n_fail++; $display("FAIL rnd_cc[%0d]: got %b required %b", n, cc, m_cc);
         end
         for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (dut.regs_q[i] !== m_regs[i]) begin
               n_fail++; $display("FAIL rnd_reg%0d[%0d]: got %h required %h", i, n, dut.regs_q[i], m_regs[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      // make sure cc and registers are nonzero before the reset
      apply(64'd10, {8'h30, 8'hF7, 64'h77}, 64'd0); commit();
      apply(64'd20, {8'h61, 8'h70, 64'd0}, 64'd0); commit();
      apply(64'd30, {8'h30, 8'hF5, 64'hABCD}, 64'd0);
      #3;
      rst_n = 1'b0;
      for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
      m_cc = 3'b000;
      #1;
      n_cmp++;
      if (cc !== 3'b000) begin
         n_fail++; $display("FAIL midreset_cc: got %b required 000", cc);
      end
      for (int i = 0; i < 15; i++) begin
         n_cmp++;
         if (dut.regs_q[i] !== 64'd0) begin
            n_fail++; $display("FAIL midreset_reg%0d: got %h required 0", i, dut.regs_q[i]);
         end
      end
      @(posedge clk); #1;
      n_cmp++;
      if (dut.regs_q[5] !== 64'd0) begin
         n_fail++; $display("FAIL reset_held_write: got %h required 0", dut.regs_q[5]);
      end
      apply(64'd40, {8'h10, 72'd0}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      commit();
      apply(64'd41, {8'h30, 8'hF5, 64'h42}, 64'd0); commit();
      n_cmp++;
      if (dut.regs_q[5] !== 64'h42 || dut.regs_q[7] !== 64'd0) begin
         n_fail++; $display("FAIL post_reset_write: got rbp=%h rdi=%h required 42 0", dut.regs_q[5], dut.regs_q[7]);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
